// File: rtl/cbus_rr_arbiter_pkg.sv
// cbus_rr_arbiter_pkg: shared CBus request/response types and index-width helper
package cbus_rr_arbiter_pkg;
    typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} cbus_size_t;
    typedef enum logic [3:0] {LEN1 = 4'd0, LEN2 = 4'd1, LEN4 = 4'd3, LEN8 = 4'd7, LEN16 = 4'd15} cbus_len_t;
    typedef enum logic [1:0] {BURST_FIXED, BURST_INCR, BURST_WRAP} cbus_burst_t;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        cbus_size_t  size;
        cbus_len_t   len;
        cbus_burst_t burst;
        logic [31:0] data;
        logic [3:0]  strobe;
    } cbus_req_t;
    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
    function automatic int idx_width(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker, first valid index after last
module rr_pick
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] last,
    output logic          any,
    output logic [IW-1:0] index
);
    logic [IW-1:0] j;
    always_comb begin
        any = |valid;
        index = '0;
        j = '0;
        // scanning downward lets the nearest index after last overwrite farther ones
        for (int k = N; k >= 1; k--) begin
            j = IW'((int'(last) + k) % N);
            index = valid[j] ? j : index;
        end
    end
endmodule

// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: round-robin merge of CBus masters onto one port, grant held for a whole transaction
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    localparam int IW = idx_width(NUM_INPUTS)
) (
    input  logic            clk,
    input  logic            reset,
    input  cbus_req_t       ireqs [NUM_INPUTS],
    output cbus_resp_t      iresps [NUM_INPUTS],
    output cbus_req_t       oreq,
    input  cbus_resp_t      oresp,
    output logic            busy,
    output logic [IW-1:0]   grant
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_next;
    logic [NUM_INPUTS-1:0] vmask;
    logic [IW-1:0] last_idx, pick_idx;
    logic pick_any, done;

    rr_pick #(.N(NUM_INPUTS)) u_pick (
        .valid(vmask),
        .last(last_idx),
        .any(pick_any),
        .index(pick_idx)
    );

    assign busy = state == BUSY;
    assign done = busy && oresp.ready && oresp.last;

    always_comb begin
        state_next = busy ? (done ? IDLE : BUSY) : (pick_any ? BUSY : IDLE);
        oreq = busy ? ireqs[grant] : '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            vmask[i] = ireqs[i].valid;
            iresps[i] = (busy && grant == IW'(i)) ? oresp : '0;
        end
    end

    // last starts at the top index so that index 0 wins the first pick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            last_idx <= IW'(NUM_INPUTS - 1);
        end else begin
            state <= state_next;
            if (!busy && pick_any)
                grant <= pick_idx;
            if (done)
                last_idx <= grant;
        end
    end
endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// tb_cbus_rr_arbiter: randomized scoreboard bench against a transaction-level round-robin model
module tb_cbus_rr_arbiter;
    import cbus_rr_arbiter_pkg::*;
    localparam int N = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    cbus_req_t ireqs [N];
    cbus_resp_t iresps [N];
    cbus_req_t oreq;
    cbus_resp_t oresp;
    logic busy;
    logic [0:0] grant;

    logic [2:0] pv;
    logic [1:0] pl;
    logic pany;
    logic [1:0] pidx;

    cbus_rr_arbiter #(.NUM_INPUTS(N)) dut (
        .clk(clk),
        .reset(reset),
        .ireqs(ireqs),
        .iresps(iresps),
        .oreq(oreq),
        .oresp(oresp),
        .busy(busy),
        .grant(grant)
    );

    rr_pick #(.N(3)) u_pick3 (.valid(pv), .last(pl), .any(pany), .index(pidx));

    always #5 clk = ~clk;

    typedef struct {
        logic        is_write;
        logic [31:0] addr;
        cbus_len_t   len;
        logic [31:0] data;
        logic [3:0]  strobe;
    } txn_t;
    typedef struct {
        int         m;
        cbus_resp_t r;
    } sb_t;

    txn_t txq [N][$];
    sb_t sbq [$];
    int checks = 0;
    int passed = 0;
    bit run = 0;
    bit rand_en = 0;
    bit model_busy = 0;
    int model_last = N - 1;
    int model_grant = 0;
    int mem_beat = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic cbus_req_t mkreq(txn_t t);
        cbus_req_t r;
        r = '0;
        r.valid = 1'b1;
        r.is_write = t.is_write;
        r.addr = t.addr;
        r.size = MSIZE4;
        r.len = t.len;
        r.burst = BURST_INCR;
        r.data = t.data;
        r.strobe = t.strobe;
        return r;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int s;
        s = $urandom_range(3);
        t.is_write = 1'($urandom_range(1));
        t.addr = $urandom;
        t.len = s == 0 ? LEN1 : s == 1 ? LEN2 : s == 2 ? LEN4 : LEN8;
        t.data = $urandom;
        t.strobe = 4'($urandom);
        return t;
    endfunction

    // round-robin rule: pending master at the smallest circular distance after the last winner
    function automatic int model_pick(int last, bit [N-1:0] pend, int n);
        int best, bd, d;
        best = -1;
        bd = n + 1;
        for (int i = 0; i < n; i++) begin
            d = (i - last - 1 + 2 * n) % n;
            if (pend[i] && d < bd) begin
                bd = d;
                best = i;
            end
        end
        return best;
    endfunction

    function automatic bit [N-1:0] pending();
        bit [N-1:0] p;
        for (int i = 0; i < N; i++) p[i] = txq[i].size() > 0;
        return p;
    endfunction

    always @(negedge clk) begin
        if (run) begin
            int p;
            if (rand_en)
                for (int i = 0; i < N; i++)
                    if (txq[i].size() < 2 && $urandom_range(99) < 30) txq[i].push_back(rand_txn());
            for (int i = 0; i < N; i++)
                ireqs[i] = txq[i].size() > 0 ? mkreq(txq[i][0]) : '0;
            #1;
            oresp.ready = model_busy && ($urandom_range(3) != 0);
            oresp.last = oresp.ready && mem_beat == int'(txq[model_grant][0].len);
            oresp.data = $urandom;
            #1;
            chk("busy", busy, model_busy);
            if (model_busy) chk("grant", grant, model_grant);
            chk("oreq", oreq, model_busy ? mkreq(txq[model_grant][0]) : '0);
            for (int i = 0; i < N; i++)
                chk("iresps_route", iresps[i], (model_busy && i == model_grant) ? oresp : '0);
            if (oresp.ready) sbq.push_back('{model_grant, oresp});
            if (model_busy && oresp.ready) begin
                mem_beat = oresp.last ? 0 : mem_beat + 1;
                if (oresp.last) begin
                    model_busy = 0;
                    model_last = model_grant;
                    void'(txq[model_grant].pop_front());
                end
            end else if (!model_busy) begin
                p = model_pick(model_last, pending(), N);
                if (p >= 0) begin
                    model_busy = 1;
                    model_grant = p;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            #3;
            for (int i = 0; i < N; i++) begin
                if (iresps[i].ready) begin
                    checks++;
                    if (sbq.size() == 0) begin
                        $display("FAIL resp_unexpected: master %0d got %h expected no response", i, iresps[i]);
                    end else begin
                        sb_t e;
                        passed++;
                        e = sbq.pop_front();
                        chk("resp_master", i, e.m);
                        chk("resp_data", iresps[i], e.r);
                    end
                end
            end
            if (sbq.size() != 0) begin
                chk("resp_missing", sbq.size(), 0);
                sbq.delete();
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((pending() != 0 || model_busy) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", n < 3000, 1);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            txq[i].delete();
            ireqs[i] = '0;
        end
        sbq.delete();
        oresp = '0;
        model_busy = 0;
        model_last = N - 1;
        model_grant = 0;
        mem_beat = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        int found;
        model_reset();
        for (int m = 0; m < 8; m++) begin
            for (int l = 0; l < 3; l++) begin
                pv = 3'(m);
                pl = 2'(l);
                #1;
                chk("pick3_any", pany, m != 0);
                if (m != 0) chk("pick3_index", pidx, model_pick(l, 2'b00, 0) < 0 ? model_pick3(l, 3'(m)) : 0);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_oreq", oreq, 0);
        chk("rst_iresps0", iresps[0], 0);
        chk("rst_iresps1", iresps[1], 0);
        @(posedge clk);
        #2 reset = 1'b0;
        run = 1;
        @(posedge clk);
        t = rand_txn();
        t.is_write = 1'b0;
        t.len = LEN4;
        txq[1].push_back(t);
        drain();
        @(posedge clk);
        t.is_write = 1'b1;
        t.addr = 32'h1fc0_0040;
        t.strobe = 4'b0011;
        txq[1].push_back(t);
        drain();
        @(posedge clk);
        for (int k = 0; k < 2; k++) txq[0].push_back(rand_txn());
        txq[1].push_back(rand_txn());
        drain();
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            txq[0].push_back(rand_txn());
            txq[1].push_back(rand_txn());
        end
        drain();
        @(posedge clk);
        t = rand_txn();
        t.len = LEN4;
        txq[1].push_back(t);
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            @(posedge clk);
            if (model_busy && mem_beat == 2) found = 1;
        end
        chk("rst_mid_reached", found, 1);
        #2;
        run = 0;
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_oreq_valid", oreq.valid, 0);
        chk("rst_mid_grant", grant, 0);
        model_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        run = 1;
        @(posedge clk);
        txq[0].push_back(rand_txn());
        txq[1].push_back(rand_txn());
        drain();
        rand_en = 1;
        repeat (3000) @(posedge clk);
        rand_en = 0;
        drain();
        repeat (3) @(posedge clk);
        run = 0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    function automatic int model_pick3(int last, bit [2:0] mask);
        int best, bd, d;
        best = -1;
        bd = 4;
        for (int i = 0; i < 3; i++) begin
            d = (i - last - 1 + 6) % 3;
            if (mask[i] && d < bd) begin
                bd = d;
                best = i;
            end
        end
        return best;
    endfunction
endmodule

// File: doc/cbus_rr_arbiter.md
# cbus_rr_arbiter

- Round-robin arbiter that merges the cache-side CBus masters (ICache, DCache, any later uncached/MMIO master) onto the single outbound CBus port at the top level.
- Grants one whole transaction at a time and locks the grant until the final beat completes.
- Fair by rotating priority.
- Routes the memory response only to the granted master.

## Interface
Parameters:
- NUM_INPUTS, default 2: number of upstream CBus masters; legal range 1..8. Index 0 is the highest priority after reset.

Ports:
- clk  in  1: system clock; all state changes on its rising edge.
- reset  in  1: asynchronous, active-high reset.
- ireqs  in  cbus_req_t [NUM_INPUTS]: per-master requests.
- iresps  out  cbus_resp_t [NUM_INPUTS]: per-master responses.
- oreq  out  cbus_req_t: merged request to memory.
- oresp  in  cbus_resp_t: memory response.
- busy  out  1: a transaction is granted and not yet finished.
- grant  out  IW: index of the granted master, where IW = max(1, $clog2(NUM_INPUTS)); valid when busy=1.

## Operation
Two states: IDLE and BUSY.

IDLE:
- oreq is all-zero; every iresps entry is all-zero.
- If any ireqs[i].valid is set, the picker chooses the first valid index scanning upward from (last+1) mod NUM_INPUTS, wrapping around.
- The chosen index is registered into grant and the state moves to BUSY.

BUSY:
- oreq = ireqs[grant], passed through combinationally, all fields.
- iresps[grant] = oresp. Every other iresps entry is all-zero, so its ready=0.
- On oresp.ready && oresp.last: last <= grant, next state IDLE.

Request rules:
- New requests arriving during BUSY wait; they are never dropped and never preempt.
- A granted master deasserting valid before last is a protocol violation. The arbiter still holds the grant until oresp.last and forwards valid=0 as-is.

Reset:
- Reset asserted at any time, including mid-burst, forces IDLE, last = NUM_INPUTS-1 (so index 0 wins first), grant = 0, busy = 0.
- The outstanding burst is abandoned. Memory is reset by the same signal.

NUM_INPUTS = 1: the picker degenerates to index 0. The IDLE bubble is kept, so behaviour stays identical.

## Timing
- Grant latency: a request asserted in cycle t (state IDLE) makes oreq.valid=1 in cycle t+1.
- Bubble: exactly one IDLE cycle between back-to-back transactions. The cycle after the last beat, oreq.valid=0.
- The response path is combinational: oresp to iresps[grant] in zero cycles. Likewise ireqs[grant] to oreq.
- No combinational path from oresp to grant or last; both are registered.
- Reset values of all outputs:
  - oreq = 0
  - iresps = 0
  - busy = 0
  - grant = 0
- Simultaneous events:
  - last beat and new requests in the same cycle: the new choice is made in the following IDLE cycle, using the updated last.
  - a master holding valid across its own completion: rotated to lowest priority for the next pick.

## Structure
- cbus_req_t, cbus_resp_t and the burst/size enums stay in the shared common package. The arbiter adds no new types.
- Local state enum {IDLE, BUSY} lives in the module.
- One sub-module: rr_pick, a combinational rotating priority picker.
  - Parameter: N.
  - Inputs: valid mask [N], last index.
  - Outputs: any, index.
  - Reusable by a future uncached/MMIO arbiter.

## Test plan
1. Reset release, only ireqs[1] valid (4-beat read, len=LEN4) → oreq.valid=1 one cycle later, grant=1. Four ready beats reach iresps[1] only; iresps[0].ready stays 0. Then one idle cycle.
2. Both masters valid in the same cycle after reset → master 0 served first. Master 1 is granted in the cycle after master 0's last beat plus one bubble. If master 0 requests again, master 1 still wins before master 0 is served.
3. Master 0 streams back-to-back transactions while master 1 waits → grants alternate 0,1,0,1; no starvation over 10 transactions.
4. Reset asserted asynchronously mid-burst (beat 2 of 4) → within the same cycle busy=0 and oreq.valid=0. After release, index 0 has priority.
5. Write burst on master 1 with strobe=4'b0011 and addr=32'h1fc0_0040 → oreq fields match ireqs[1] bit-exactly on every beat.
6. NUM_INPUTS=3: masters 0 and 2 valid, last=0 → grant=2, skipping the idle master 1.
